// File: rtl/windowed_register_file.sv
// SPARC windowed integer register file: 7 globals plus NWINDOWS overlapping
// 16-entry windows, with CWP/WIM state and SAVE/RESTORE trap detection.
module windowed_register_file #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NWINDOWS = 4,
  localparam int unsigned CW      = $clog2(NWINDOWS)
) (
  input  logic                Clk,
  input  logic                Clr,
  input  logic [4:0]          RdAddrA,
  input  logic [4:0]          RdAddrB,
  output logic [WIDTH-1:0]    PortA,
  output logic [WIDTH-1:0]    PortB,
  input  logic [4:0]          WrAddr,
  input  logic [WIDTH-1:0]    WrData,
  input  logic                WrEn,
  input  logic                Save,
  input  logic                Restore,
  input  logic                CwpLd,
  input  logic [CW-1:0]       CwpIn,
  input  logic                WimLd,
  input  logic [NWINDOWS-1:0] WimIn,
  input  logic                TrapAck,
  output logic [CW-1:0]       Cwp,
  output logic [NWINDOWS-1:0] Wim,
  output logic                TrapPend,
  output logic [1:0]          TrapType
);

  localparam int unsigned NPHYS = NWINDOWS * 16;
  localparam int unsigned PW    = CW + 4;

  localparam logic [1:0] TRAP_NONE = 2'b00;
  localparam logic [1:0] TRAP_OVF  = 2'b01;
  localparam logic [1:0] TRAP_UNF  = 2'b10;

  logic [WIDTH-1:0]    glob_q [8];
  logic [WIDTH-1:0]    win_q  [NPHYS];

  logic [CW-1:0]       cwp_q, cwp_d;
  logic [NWINDOWS-1:0] wim_q, wim_d;
  logic                pend_q, pend_d;
  logic [1:0]          type_q, type_d;
  logic [CW-1:0]       save_tgt;
  logic [CW-1:0]       rest_tgt;

  // Windowed address r8..r31 -> physical slot; ins of window w wrap onto outs of w+1.
  function automatic logic [PW-1:0] phys_idx(input logic [CW-1:0] cwp,
                                             input logic [4:0]    a);
    phys_idx = {cwp, 4'b0000} + PW'(a - 5'd8);
  endfunction

  // Combinational read ports; r0 always reads zero.
  always_comb begin
    PortA = '0;
    if (RdAddrA[4:3] != 2'b00) begin
      PortA = win_q[phys_idx(cwp_q, RdAddrA)];
    end else if (RdAddrA[2:0] != 3'b000) begin
      PortA = glob_q[RdAddrA[2:0]];
    end
  end

  always_comb begin
    PortB = '0;
    if (RdAddrB[4:3] != 2'b00) begin
      PortB = win_q[phys_idx(cwp_q, RdAddrB)];
    end else if (RdAddrB[2:0] != 3'b000) begin
      PortB = glob_q[RdAddrB[2:0]];
    end
  end

  // Register storage; writes use the window in effect before any same-cycle move.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      for (int i = 0; i < 8; i++) begin
        glob_q[i] <= '0;
      end
      for (int i = 0; i < int'(NPHYS); i++) begin
        win_q[i] <= '0;
      end
    end else if (WrEn) begin
      if (WrAddr[4:3] != 2'b00) begin
        win_q[phys_idx(cwp_q, WrAddr)] <= WrData;
      end else if (WrAddr[2:0] != 3'b000) begin
        glob_q[WrAddr[2:0]] <= WrData;
      end
    end
  end

  // Window control next state: CwpLd beats moves, moves are frozen while a trap is pending.
  always_comb begin
    cwp_d    = cwp_q;
    wim_d    = wim_q;
    pend_d   = pend_q;
    type_d   = type_q;
    save_tgt = cwp_q - CW'(1);
    rest_tgt = cwp_q + CW'(1);

    if (WimLd) begin
      wim_d = WimIn;
    end

    if (pend_q && TrapAck) begin
      pend_d = 1'b0;
      type_d = TRAP_NONE;
    end

    if (CwpLd) begin
      cwp_d = CwpIn;
    end else if (!pend_q && (Save ^ Restore)) begin
      if (Save) begin
        if (wim_q[save_tgt]) begin
          pend_d = 1'b1;
          type_d = TRAP_OVF;
        end else begin
          cwp_d = save_tgt;
        end
      end else begin
        if (wim_q[rest_tgt]) begin
          pend_d = 1'b1;
          type_d = TRAP_UNF;
        end else begin
          cwp_d = rest_tgt;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      cwp_q  <= '0;
      wim_q  <= '0;
      pend_q <= 1'b0;
      type_q <= TRAP_NONE;
    end else begin
      cwp_q  <= cwp_d;
      wim_q  <= wim_d;
      pend_q <= pend_d;
      type_q <= type_d;
    end
  end

  assign Cwp      = cwp_q;
  assign Wim      = wim_q;
  assign TrapPend = pend_q;
  assign TrapType = type_q;

endmodule

// File: tb/tb_windowed_register_file.sv
// Bench for windowed_register_file: directed scenarios plus randomized traffic
// checked every cycle against an architectural model of the register windows.
module tb_windowed_register_file;

  localparam int NWI = 4;

  logic        Clk = 1'b0;
  logic        Clr;
  logic [4:0]  RdAddrA, RdAddrB, WrAddr;
  logic [31:0] WrData, PortA, PortB;
  logic        WrEn, Save, Restore, CwpLd, WimLd, TrapAck;
  logic [1:0]  CwpIn;
  logic [3:0]  WimIn;
  logic [1:0]  Cwp;
  logic [3:0]  Wim;
  logic        TrapPend;
  logic [1:0]  TrapType;

  logic        e_Clr;
  logic [4:0]  e_RdAddrA, e_RdAddrB, e_WrAddr;
  logic [31:0] e_WrData, e_PortA, e_PortB;
  logic        e_WrEn, e_Save, e_Restore, e_CwpLd, e_WimLd, e_TrapAck;
  logic [2:0]  e_CwpIn;
  logic [7:0]  e_WimIn;
  logic [2:0]  e_Cwp;
  logic [7:0]  e_Wim;
  logic        e_TrapPend;
  logic [1:0]  e_TrapType;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_glob [8];
  logic [31:0] m_win  [NWI*16];
  int          m_cwp;
  logic [3:0]  m_wim;
  bit          m_pend;
  logic [1:0]  m_type;

  windowed_register_file #(.WIDTH(32), .NWINDOWS(4)) u_dut (
    .Clk(Clk), .Clr(Clr), .RdAddrA(RdAddrA), .RdAddrB(RdAddrB),
    .PortA(PortA), .PortB(PortB), .WrAddr(WrAddr), .WrData(WrData),
    .WrEn(WrEn), .Save(Save), .Restore(Restore), .CwpLd(CwpLd),
    .CwpIn(CwpIn), .WimLd(WimLd), .WimIn(WimIn), .TrapAck(TrapAck),
    .Cwp(Cwp), .Wim(Wim), .TrapPend(TrapPend), .TrapType(TrapType)
  );

  windowed_register_file #(.WIDTH(32), .NWINDOWS(8)) u_dut8 (
    .Clk(Clk), .Clr(e_Clr), .RdAddrA(e_RdAddrA), .RdAddrB(e_RdAddrB),
    .PortA(e_PortA), .PortB(e_PortB), .WrAddr(e_WrAddr), .WrData(e_WrData),
    .WrEn(e_WrEn), .Save(e_Save), .Restore(e_Restore), .CwpLd(e_CwpLd),
    .CwpIn(e_CwpIn), .WimLd(e_WimLd), .WimIn(e_WimIn), .TrapAck(e_TrapAck),
    .Cwp(e_Cwp), .Wim(e_Wim), .TrapPend(e_TrapPend), .TrapType(e_TrapType)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Architectural view: a register in window w lives at (w*16 + a-8) mod (N*16).
  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (a < 5'd8) return m_glob[a[2:0]];
    return m_win[(m_cwp * 16 + int'(a) - 8) % (NWI * 16)];
  endfunction

  task automatic model_step();
    logic [3:0] old_wim;
    bit         old_pend;
    int         t;
    if (Clr) begin
      for (int i = 0; i < 8; i++) m_glob[i] = 32'd0;
      for (int i = 0; i < NWI * 16; i++) m_win[i] = 32'd0;
      m_cwp  = 0;
      m_wim  = 4'd0;
      m_pend = 1'b0;
      m_type = 2'd0;
    end else begin
      if (WrEn && WrAddr != 5'd0) begin
        if (WrAddr < 5'd8) m_glob[WrAddr[2:0]] = WrData;
        else m_win[(m_cwp * 16 + int'(WrAddr) - 8) % (NWI * 16)] = WrData;
      end
      old_wim  = m_wim;
      old_pend = m_pend;
      if (WimLd) m_wim = WimIn;
      if (old_pend && TrapAck) begin
        m_pend = 1'b0;
        m_type = 2'd0;
      end
      if (CwpLd) begin
        m_cwp = int'(CwpIn);
      end else if (!old_pend && (Save != Restore)) begin
        t = Save ? (m_cwp + NWI - 1) % NWI : (m_cwp + 1) % NWI;
        if (old_wim[t]) begin
          m_pend = 1'b1;
          m_type = Save ? 2'd1 : 2'd2;
        end else begin
          m_cwp = t;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge Clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    Clr = 1'b0; WrEn = 1'b0; Save = 1'b0; Restore = 1'b0;
    CwpLd = 1'b0; WimLd = 1'b0; TrapAck = 1'b0;
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    if (chk_en) begin
      check("PortA", PortA, mread(RdAddrA));
      check("PortB", PortB, mread(RdAddrB));
      check("Cwp", 32'(Cwp), 32'(m_cwp));
      check("Wim", 32'(Wim), 32'(m_wim));
      check("TrapPend", 32'(TrapPend), 32'(m_pend));
      check("TrapType", 32'(TrapType), 32'(m_type));
    end
  end

  initial begin
    idle();
    Clr = 1'b1;
    RdAddrA = 5'd0; RdAddrB = 5'd1; WrAddr = 5'd0; WrData = 32'd0;
    CwpIn = 2'd0; WimIn = 4'd0;
    e_Clr = 1'b1; e_RdAddrA = 5'd0; e_RdAddrB = 5'd0; e_WrAddr = 5'd0;
    e_WrData = 32'd0; e_WrEn = 1'b0; e_Save = 1'b0; e_Restore = 1'b0;
    e_CwpLd = 1'b0; e_CwpIn = 3'd0; e_WimLd = 1'b0; e_WimIn = 8'd0; e_TrapAck = 1'b0;
    cycle();
    Clr = 1'b0; e_Clr = 1'b0;
    chk_en = 1'b1;
    check("reset_cwp", 32'(Cwp), 32'd0);
    check("reset_r1", PortB, 32'd0);
    check("reset_pend", 32'(TrapPend), 32'd0);

    // SAVE exposes the caller's outs as the callee's ins
    WrAddr = 5'd9; WrData = 32'hAAAA_0001; WrEn = 1'b1; cycle(); WrEn = 1'b0;
    Save = 1'b1; cycle(); Save = 1'b0;
    check("save_cwp", 32'(Cwp), 32'd3);
    RdAddrA = 5'd25; #1;
    check("in_alias_r25", PortA, 32'hAAAA_0001);
    Restore = 1'b1; cycle(); Restore = 1'b0;
    RdAddrA = 5'd9; #1;
    check("restore_cwp", 32'(Cwp), 32'd0);
    check("restore_r9", PortA, 32'hAAAA_0001);

    // Last window's ins wrap onto window 0 outs
    CwpLd = 1'b1; CwpIn = 2'd3; cycle(); CwpLd = 1'b0;
    WrAddr = 5'd24; WrData = 32'h0000_1234; WrEn = 1'b1; cycle(); WrEn = 1'b0;
    CwpLd = 1'b1; CwpIn = 2'd0; cycle(); CwpLd = 1'b0;
    RdAddrA = 5'd8; #1;
    check("wrap_r8", PortA, 32'h0000_1234);

    WrAddr = 5'd3; WrData = 32'hCAFE_F00D; WrEn = 1'b1; cycle(); WrEn = 1'b0;
    RdAddrB = 5'd3;
    for (int w = 0; w < NWI; w++) begin
      CwpLd = 1'b1; CwpIn = 2'(w); cycle(); CwpLd = 1'b0;
      check("global_r3", PortB, 32'hCAFE_F00D);
    end
    WrAddr = 5'd0; WrData = 32'hFFFF_FFFF; WrEn = 1'b1; cycle(); WrEn = 1'b0;
    RdAddrB = 5'd0; #1;
    check("r0_zero", PortB, 32'd0);
    CwpLd = 1'b1; CwpIn = 2'd0; cycle(); CwpLd = 1'b0;

    // Overflow: requests frozen while pending, including the ack cycle
    WimLd = 1'b1; WimIn = 4'b1000; cycle(); WimLd = 1'b0;
    Save = 1'b1; cycle();
    check("ovf_cwp", 32'(Cwp), 32'd0);
    check("ovf_pend", 32'(TrapPend), 32'd1);
    check("ovf_type", 32'(TrapType), 32'd1);
    cycle();
    check("ovf_save_ignored", 32'(Cwp), 32'd0);
    TrapAck = 1'b1; cycle(); TrapAck = 1'b0; Save = 1'b0;
    check("ack_pend", 32'(TrapPend), 32'd0);
    check("ack_type", 32'(TrapType), 32'd0);
    check("ack_cycle_save_ignored", 32'(Cwp), 32'd0);

    // Underflow decided on the old WIM despite same-cycle load
    WimLd = 1'b1; WimIn = 4'b0010; cycle();
    Restore = 1'b1; WimIn = 4'b0000; cycle(); Restore = 1'b0; WimLd = 1'b0;
    check("unf_type", 32'(TrapType), 32'd2);
    check("unf_cwp", 32'(Cwp), 32'd0);
    check("unf_wim", 32'(Wim), 32'd0);
    TrapAck = 1'b1; cycle(); TrapAck = 1'b0;

    Save = 1'b1; Restore = 1'b1; cycle(); Save = 1'b0; Restore = 1'b0;
    check("both_cwp", 32'(Cwp), 32'd0);
    check("both_notrap", 32'(TrapPend), 32'd0);
    CwpLd = 1'b1; CwpIn = 2'd2; Save = 1'b1; cycle(); CwpLd = 1'b0; Save = 1'b0;
    check("cwpld_beats_save", 32'(Cwp), 32'd2);
    WrAddr = 5'd16; WrData = 32'h5EED_0016; WrEn = 1'b1; Save = 1'b1; cycle();
    WrEn = 1'b0; Save = 1'b0;
    check("wr_save_cwp", 32'(Cwp), 32'd1);
    Restore = 1'b1; cycle(); Restore = 1'b0;
    RdAddrA = 5'd16; #1;
    check("wr_old_window", PortA, 32'h5EED_0016);

    // Held SAVE walks windows until it meets an invalid one
    WimLd = 1'b1; WimIn = 4'b0001; cycle(); WimLd = 1'b0;
    Save = 1'b1; cycle(); cycle(); cycle();
    check("held_save_cwp", 32'(Cwp), 32'd1);
    check("held_save_type", 32'(TrapType), 32'd1);
    Clr = 1'b1; cycle(); Clr = 1'b0; Save = 1'b0;
    check("clr_trap_pend", 32'(TrapPend), 32'd0);
    check("clr_trap_cwp", 32'(Cwp), 32'd0);
    check("clr_r16", PortA, 32'd0);

    // Eight-window instance: reset in the middle of a pending overflow
    e_WrAddr = 5'd1; e_WrData = 32'h1111_1111; e_WrEn = 1'b1; cycle();
    e_WrAddr = 5'd8; e_WrData = 32'h2222_2222; cycle(); e_WrEn = 1'b0;
    e_RdAddrA = 5'd1; e_RdAddrB = 5'd8; #1;
    check("n8_r1", e_PortA, 32'h1111_1111);
    check("n8_r8", e_PortB, 32'h2222_2222);
    e_WimLd = 1'b1; e_WimIn = 8'h80; cycle(); e_WimLd = 1'b0;
    e_Save = 1'b1; cycle(); e_Save = 1'b0;
    check("n8_ovf_pend", 32'(e_TrapPend), 32'd1);
    check("n8_ovf_type", 32'(e_TrapType), 32'd1);
    check("n8_ovf_cwp", 32'(e_Cwp), 32'd0);
    e_Clr = 1'b1; cycle(); e_Clr = 1'b0;
    check("n8_clr_pend", 32'(e_TrapPend), 32'd0);
    check("n8_clr_cwp", 32'(e_Cwp), 32'd0);
    check("n8_clr_wim", 32'(e_Wim), 32'd0);
    check("n8_clr_r1", e_PortA, 32'd0);
    check("n8_clr_r8", e_PortB, 32'd0);

    // Randomized traffic, checked every cycle by the compare process
    for (int n = 0; n < 3000; n++) begin
      Clr     = ($urandom_range(0, 199) == 0);
      RdAddrA = 5'($urandom);
      RdAddrB = 5'($urandom);
      WrAddr  = 5'($urandom);
      WrData  = $urandom;
      WrEn    = 1'($urandom_range(0, 1));
      Save    = ($urandom_range(0, 3) == 0);
      Restore = ($urandom_range(0, 3) == 0);
      CwpLd   = ($urandom_range(0, 19) == 0);
      CwpIn   = 2'($urandom);
      WimLd   = ($urandom_range(0, 9) == 0);
      WimIn   = 4'($urandom & $urandom);
      TrapAck = ($urandom_range(0, 2) == 0);
      cycle();
    end

    idle();
    cycle();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
